// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package chunked_adder_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to index n items; never less than 1 so a single-chunk
    // build still has a legal index register.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = (n > 1) ? n - 1 : 0;
        while (v != 0) begin
            w++;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// Optional port sub exists only when CHUNKED_ADDER_SUB_EN is defined.
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CHUNKED_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/chunked_adder_chunk_adder.sv
// CHUNK-bit combinational data-flow adder, reused every cycle by chunked_adder.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(cin);

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock with a
// registered carry between chunks; valid/ready on input and output.
// Define CHUNKED_ADDER_SUB_EN to add the sub port (a - b mode).
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic           clk,
    input logic           rst,
    chunked_adder_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = clog2(NCHUNK);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       base;
    logic [CHUNK-1:0]  ch_a, ch_b, ch_s;
    logic              ch_c;
    logic              last_chunk;
    logic              msb_cin;

    // Select the active chunk; shifting by a bit offset avoids a wide
    // variable part-select index.
    always_comb begin
        base       = 32'(idx_q) * 32'(CHUNK);
        ch_a       = CHUNK'(op_a_q >> base);
        ch_b       = CHUNK'(op_b_q >> base);
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
        // Carry into the MSB recovered from the top bit of the last chunk.
        msb_cin    = ch_a[CHUNK-1] ^ ch_b[CHUNK-1] ^ ch_s[CHUNK-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (ch_a),
        .b     (ch_b),
        .cin   (carry_q),
        .sum   (ch_s),
        .carry (ch_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_chunk)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath next values: latch operands, then add one chunk per cycle.
    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d = bus.a;
`ifdef CHUNKED_ADDER_SUB_EN
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    op_b_d  = bus.b;
                    carry_d = bus.cin;
`endif
                    idx_d = '0;
                    sum_d = '0;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << base)) | (WIDTH'(ch_s) << base);
                carry_d = ch_c;
                idx_d   = idx_q + IDXW'(1);
                if (last_chunk) begin
                    cout_d = ch_c;
                    ovf_d  = msb_cin ^ ch_c;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: a 16/4 instance and a 1/1 instance.
module tb_chunked_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus16 ();
    chunked_adder_if #(.WIDTH(1))  bus1 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    chunked_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp16_t;

    typedef struct packed {
        logic sum;
        logic cout;
        logic ovf;
    } exp1_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec16_t;

    exp16_t q16[$];
    exp1_t  q1[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor, 16-bit instance: compare on each accepted output.
    always @(negedge clk) begin : mon16
        exp16_t e;
        if (rst === 1'b0 && bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut16_unexpected_output: got sum 0x%0h required no output", bus16.sum);
            end else begin
                e = q16.pop_front();
                check("dut16_sum",  32'(bus16.sum),  32'(e.sum));
                check("dut16_cout", 32'(bus16.cout), 32'(e.cout));
                check("dut16_ovf",  32'(bus16.ovf),  32'(e.ovf));
            end
        end
    end

    // Result monitor, 1-bit instance.
    always @(negedge clk) begin : mon1
        exp1_t e;
        if (rst === 1'b0 && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_output: got sum %0b required no output", bus1.sum);
            end else begin
                e = q1.pop_front();
                check("dut1_sum",  32'(bus1.sum),  32'(e.sum));
                check("dut1_cout", 32'(bus1.cout), 32'(e.cout));
                check("dut1_ovf",  32'(bus1.ovf),  32'(e.ovf));
            end
        end
    end

    // Present one operand set to the 16-bit instance; returns #1 after the accept edge.
    task automatic issue16(input vec16_t v, input bit push);
        int n;
        n = 0;
        while (bus16.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("dut16_in_ready_timeout", 32'(bus16.in_ready), 32'd1);
        bus16.a   = v.a;
        bus16.b   = v.b;
        bus16.cin = v.cin;
`ifdef CHUNKED_ADDER_SUB_EN
        bus16.sub = v.sub;
`endif
        bus16.in_valid = 1'b1;
        if (push) q16.push_back('{sum: v.es, cout: v.ec, ovf: v.eo});
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic wait_out16(input int lat);
        int n;
        n = 0;
        while (bus16.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("dut16_latency", 32'(n), 32'(lat));
    endtask

    task automatic run16(input vec16_t v);
        issue16(v, 1'b1);
        wait_out16(4);
        @(posedge clk); #1;
    endtask

    task automatic run1(input logic a, input logic b, input logic cin,
                        input logic es, input logic ec, input logic eo);
        int n;
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = cin;
        bus1.in_valid = 1'b1;
        q1.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        while (bus1.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("dut1_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
    endtask

    vec16_t vecs[5] = '{
        '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sub: 1'b0, es: 16'h0002, ec: 1'b0, eo: 1'b0},
        '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, es: 16'h0000, ec: 1'b1, eo: 1'b0},
        '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, es: 16'h8000, ec: 1'b0, eo: 1'b1},
        '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sub: 1'b0, es: 16'h0000, ec: 1'b1, eo: 1'b1},
        '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sub: 1'b0, es: 16'hFFFF, ec: 1'b1, eo: 1'b0}
    };

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst            = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus16.cin      = 1'b0;
        bus16.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.cin       = 1'b0;
        bus1.out_ready = 1'b1;
`ifdef CHUNKED_ADDER_SUB_EN
        bus16.sub = 1'b0;
        bus1.sub  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(bus16.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus16.out_valid), 32'd0);
        check("reset_sum",       32'(bus16.sum),       32'd0);
        check("reset_cout",      32'(bus16.cout),      32'd0);
        check("reset_ovf",       32'(bus16.ovf),       32'd0);
        check("reset1_in_ready", 32'(bus1.in_ready),   32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed add vectors.
        foreach (vecs[i]) run16(vecs[i]);

        // Backpressure: result held while out_ready is low.
        bus16.out_ready = 1'b0;
        issue16('{a: 16'h1234, b: 16'h4321, cin: 1'b1, sub: 1'b0,
                  es: 16'h5556, ec: 1'b0, eo: 1'b0}, 1'b1);
        wait_out16(4);
        for (int i = 0; i < 5; i++) begin
            bus16.in_valid = (i % 2 == 0);
            bus16.a        = 16'(32'hA5A5 + i);
            bus16.b        = 16'(32'h0F0F * (i + 1));
            @(posedge clk); #1;
            check("bp_sum",       32'(bus16.sum),       32'h5556);
            check("bp_cout",      32'(bus16.cout),      32'd0);
            check("bp_ovf",       32'(bus16.ovf),       32'd0);
            check("bp_in_ready",  32'(bus16.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus16.out_valid), 32'd1);
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_in_ready",  32'(bus16.in_ready),  32'd1);
        check("drain_out_valid", 32'(bus16.out_valid), 32'd0);
        check("drain_sum_held",  32'(bus16.sum),       32'h5556);
        @(posedge clk); #1;
        check("idle_stays_idle", 32'(bus16.in_ready),  32'd1);

        // Reset while idx==2 discards the operation.
        issue16('{a: 16'h1234, b: 16'h1111, cin: 1'b0, sub: 1'b0,
                  es: 16'h0000, ec: 1'b0, eo: 1'b0}, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  32'(bus16.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("midrst_sum",       32'(bus16.sum),       32'd0);
        run16('{a: 16'h0003, b: 16'h0004, cin: 1'b0, sub: 1'b0,
                es: 16'h0007, ec: 1'b0, eo: 1'b0});

`ifdef CHUNKED_ADDER_SUB_EN
        run16('{a: 16'h0005, b: 16'h0007, cin: 1'b1, sub: 1'b1,
                es: 16'hFFFE, ec: 1'b0, eo: 1'b0});
        run16('{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1,
                es: 16'h7FFF, ec: 1'b1, eo: 1'b1});
`endif

        // Degenerate single-bit instance.
        run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q1_drained",  32'(q1.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
